wavepool_instr_queue: RTL and testbench

//  Per-CU instruction queue between fetch return and the wavepool->decode flop stage.

---
 rtl/wavepool_instr_queue.sv | 131 +++++++++++++
 tb/tb_wavepool_instr_queue.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wavepool_instr_queue.sv
// Per-CU wavepool instruction queue: circular buffer of fetched instructions with wave context,
// per-wfid flush, decode stall. Define WAVEPOOL_IQ_STATS_EN to add issued/killed counters.
module wavepool_instr_queue #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fetch_valid,
    output logic             fetch_ready,
    input  logic [31:0]      fetch_pc,
    input  logic [31:0]      fetch_instr,
    input  logic [5:0]       fetch_wfid,
    input  logic [9:0]       fetch_vgpr_base,
    input  logic [8:0]       fetch_sgpr_base,
    input  logic [15:0]      fetch_lds_base,
    input  logic             decode_stall,
    input  logic             flush_valid,
    input  logic [5:0]       flush_wfid,
    output logic             wave_instr_valid,
    output logic [31:0]      wave_instr_pc,
    output logic [31:0]      wave_instr,
    output logic [5:0]       wave_wfid,
    output logic [9:0]       wave_vgpr_base,
    output logic [8:0]       wave_sgpr_base,
    output logic [15:0]      wave_lds_base,
    output logic [PTR_W:0]   queue_count
`ifdef WAVEPOOL_IQ_STATS_EN
    ,
    output logic [31:0]      stat_issued,
    output logic [31:0]      stat_killed
`endif
);

    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE    = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [PTR_W:0]   count_q;
    logic [DEPTH-1:0] live_q;

    logic [31:0] pc_q    [DEPTH];
    logic [31:0] instr_q [DEPTH];
    logic [5:0]  wfid_q  [DEPTH];
    logic [9:0]  vgpr_q  [DEPTH];
    logic [8:0]  sgpr_q  [DEPTH];
    logic [15:0] lds_q   [DEPTH];

    logic non_empty, head_flushed, head_hit, push, pop;

    always_comb begin
        fetch_ready      = (count_q < FULL_COUNT);
        non_empty        = (count_q != '0);
        head_flushed     = flush_valid && (wfid_q[rd_ptr_q] == flush_wfid);
        head_hit         = non_empty && live_q[rd_ptr_q] && !head_flushed;
        wave_instr_valid = head_hit && !decode_stall;
        push             = fetch_valid && fetch_ready;
        // Dead or flushed heads drain even under decode_stall.
        pop              = non_empty && (!head_hit || !decode_stall);
    end

    always_comb begin
        wave_instr_pc  = '0;
        wave_instr     = '0;
        wave_wfid      = '0;
        wave_vgpr_base = '0;
        wave_sgpr_base = '0;
        wave_lds_base  = '0;
        if (wave_instr_valid) begin
            wave_instr_pc  = pc_q[rd_ptr_q];
            wave_instr     = instr_q[rd_ptr_q];
            wave_wfid      = wfid_q[rd_ptr_q];
            wave_vgpr_base = vgpr_q[rd_ptr_q];
            wave_sgpr_base = sgpr_q[rd_ptr_q];
            wave_lds_base  = lds_q[rd_ptr_q];
        end
    end

    assign queue_count = count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            live_q   <= '0;
        end else begin
            if (flush_valid) begin
                for (int unsigned i = 0; i < unsigned'(DEPTH); i++) begin
                    if (wfid_q[i] == flush_wfid) live_q[i] <= 1'b0;
                end
            end
            // Push overrides the flush clear on the (unoccupied) write slot.
            if (push) begin
                live_q[wr_ptr_q] <= !(flush_valid && (fetch_wfid == flush_wfid));
                wr_ptr_q         <= wr_ptr_q + PTR_ONE;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PTR_ONE;
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_q[wr_ptr_q]    <= fetch_pc;
            instr_q[wr_ptr_q] <= fetch_instr;
            wfid_q[wr_ptr_q]  <= fetch_wfid;
            vgpr_q[wr_ptr_q]  <= fetch_vgpr_base;
            sgpr_q[wr_ptr_q]  <= fetch_sgpr_base;
            lds_q[wr_ptr_q]   <= fetch_lds_base;
        end
    end

`ifdef WAVEPOOL_IQ_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_issued <= '0;
            stat_killed <= '0;
        end else begin
            if (wave_instr_valid)     stat_issued <= stat_issued + 32'd1;
            if (pop && !head_hit)     stat_killed <= stat_killed + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wavepool_instr_queue.sv
// Directed self-checking bench for wavepool_instr_queue (push/issue, full, flush, reset, wrap).
module tb_wavepool_instr_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_instr;
    logic [5:0]  fetch_wfid;
    logic [9:0]  fetch_vgpr_base;
    logic [8:0]  fetch_sgpr_base;
    logic [15:0] fetch_lds_base;
    logic        decode_stall;
    logic        flush_valid;
    logic [5:0]  flush_wfid;
    logic        wave_instr_valid;
    logic [31:0] wave_instr_pc;
    logic [31:0] wave_instr;
    logic [5:0]  wave_wfid;
    logic [9:0]  wave_vgpr_base;
    logic [8:0]  wave_sgpr_base;
    logic [15:0] wave_lds_base;
    logic [3:0]  queue_count;
`ifdef WAVEPOOL_IQ_STATS_EN
    logic [31:0] stat_issued;
    logic [31:0] stat_killed;
`endif

    int checks = 0;
    int errors = 0;

    wavepool_instr_queue #(.DEPTH(8), .PTR_W(3)) dut (
        .clk             (clk),
        .rst             (rst),
        .fetch_valid     (fetch_valid),
        .fetch_ready     (fetch_ready),
        .fetch_pc        (fetch_pc),
        .fetch_instr     (fetch_instr),
        .fetch_wfid      (fetch_wfid),
        .fetch_vgpr_base (fetch_vgpr_base),
        .fetch_sgpr_base (fetch_sgpr_base),
        .fetch_lds_base  (fetch_lds_base),
        .decode_stall    (decode_stall),
        .flush_valid     (flush_valid),
        .flush_wfid      (flush_wfid),
        .wave_instr_valid(wave_instr_valid),
        .wave_instr_pc   (wave_instr_pc),
        .wave_instr      (wave_instr),
        .wave_wfid       (wave_wfid),
        .wave_vgpr_base  (wave_vgpr_base),
        .wave_sgpr_base  (wave_sgpr_base),
        .wave_lds_base   (wave_lds_base),
        .queue_count     (queue_count)
`ifdef WAVEPOOL_IQ_STATS_EN
        ,
        .stat_issued     (stat_issued),
        .stat_killed     (stat_killed)
`endif
    );

    always #5 clk = ~clk;

    // Side fields are derived from pc so every issued entry is distinguishable.
    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0000;
    endfunction
    function automatic logic [9:0] vgpr_of(input logic [31:0] pc);
        return pc[11:2];
    endfunction
    function automatic logic [8:0] sgpr_of(input logic [31:0] pc);
        return pc[10:2] ^ 9'h1AB;
    endfunction
    function automatic logic [15:0] lds_of(input logic [31:0] pc);
        return pc[15:0] + 16'h1000;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_fetch(input logic v, input logic [31:0] pc, input logic [5:0] wfid);
        fetch_valid     = v;
        fetch_pc        = pc;
        fetch_wfid      = wfid;
        fetch_instr     = instr_of(pc);
        fetch_vgpr_base = vgpr_of(pc);
        fetch_sgpr_base = sgpr_of(pc);
        fetch_lds_base  = lds_of(pc);
    endtask

    task automatic expect_issue(input string tag, input logic [31:0] pc, input logic [5:0] wfid);
        #1;
        check({tag, ".valid"}, 32'(wave_instr_valid), 32'd1);
        check({tag, ".pc"},    wave_instr_pc, pc);
        check({tag, ".instr"}, wave_instr, instr_of(pc));
        check({tag, ".wfid"},  32'(wave_wfid), 32'(wfid));
        check({tag, ".vgpr"},  32'(wave_vgpr_base), 32'(vgpr_of(pc)));
        check({tag, ".sgpr"},  32'(wave_sgpr_base), 32'(sgpr_of(pc)));
        check({tag, ".lds"},   32'(wave_lds_base), 32'(lds_of(pc)));
    endtask

    task automatic expect_idle(input string tag);
        #1;
        check({tag, ".valid"}, 32'(wave_instr_valid), 32'd0);
        check({tag, ".pc0"},   wave_instr_pc, 32'd0);
        check({tag, ".wfid0"}, 32'(wave_wfid), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        decode_stall = 1'b0;
        flush_valid = 1'b0;
        flush_wfid = '0;
        drive_fetch(1'b0, 32'd0, 6'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst.count", 32'(queue_count), 32'd0);
        check("rst.ready", 32'(fetch_ready), 32'd1);
        expect_idle("rst");

        // 1: three pushes, no stall, issue in order, no bypass
        drive_fetch(1'b1, 32'h100, 6'd5);
        expect_idle("t1.nobypass");
        tick();
        drive_fetch(1'b1, 32'h104, 6'd5);
        expect_issue("t1.i0", 32'h100, 6'd5);
        tick();
        drive_fetch(1'b1, 32'h108, 6'd5);
        expect_issue("t1.i1", 32'h104, 6'd5);
        tick();
        drive_fetch(1'b0, 32'h0, 6'd0);
        expect_issue("t1.i2", 32'h108, 6'd5);
        tick();
        check("t1.count", 32'(queue_count), 32'd0);
        expect_idle("t1.empty");

        // 2: fill under stall, 9th held until space
        decode_stall = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive_fetch(1'b1, 32'h200 + 32'(4 * i), 6'd7);
            #1;
            check("t2.fill_ready", 32'(fetch_ready), 32'd1);
            check("t2.stall_novalid", 32'(wave_instr_valid), 32'd0);
            tick();
        end
        drive_fetch(1'b1, 32'h220, 6'd7);
        #1;
        check("t2.full_count", 32'(queue_count), 32'd8);
        check("t2.full_ready", 32'(fetch_ready), 32'd0);
        expect_idle("t2.full_stall");
        tick();
        check("t2.held_count", 32'(queue_count), 32'd8);
        decode_stall = 1'b0;
        for (int k = 0; k < 9; k++) begin
            expect_issue("t2.drain", 32'h200 + 32'(4 * k), 6'd7);
            if (k == 0) begin
                check("t2.k0_ready", 32'(fetch_ready), 32'd0);
                check("t2.k0_count", 32'(queue_count), 32'd8);
            end
            if (k == 1) begin
                check("t2.k1_ready", 32'(fetch_ready), 32'd1);
                check("t2.k1_count", 32'(queue_count), 32'd7);
            end
            tick();
            if (k == 1) drive_fetch(1'b0, 32'h0, 6'd0);
        end
        check("t2.end_count", 32'(queue_count), 32'd0);
        check("t2.end_ready", 32'(fetch_ready), 32'd1);
        expect_idle("t2.end");

        // 3: wfid 1,2,1,2 then flush wfid 1
        decode_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_fetch(1'b1, 32'h300 + 32'(4 * i), (i % 2 == 0) ? 6'd1 : 6'd2);
            tick();
        end
        drive_fetch(1'b0, 32'h0, 6'd0);
        flush_valid = 1'b1;
        flush_wfid = 6'd1;
        expect_idle("t3.drain_flush");
        tick();
        flush_valid = 1'b0;
        check("t3.count_after_flush", 32'(queue_count), 32'd3);
        decode_stall = 1'b0;
        expect_issue("t3.w2a", 32'h304, 6'd2);
        tick();
        expect_idle("t3.drain_dead");
        tick();
        expect_issue("t3.w2b", 32'h30C, 6'd2);
        tick();
        check("t3.count_end", 32'(queue_count), 32'd0);

        // 4: flush hits head and same-cycle push of the same wfid
        decode_stall = 1'b1;
        drive_fetch(1'b1, 32'h400, 6'd3);
        tick();
        decode_stall = 1'b0;
        drive_fetch(1'b1, 32'h404, 6'd3);
        flush_valid = 1'b1;
        flush_wfid = 6'd3;
        expect_idle("t4.head_flushed");
        tick();
        flush_valid = 1'b0;
        check("t4.count", 32'(queue_count), 32'd1);
        drive_fetch(1'b1, 32'h408, 6'd4);
        expect_idle("t4.pushed_dead");
        tick();
        drive_fetch(1'b0, 32'h0, 6'd0);
        expect_issue("t4.other_wfid", 32'h408, 6'd4);
        tick();
        check("t4.count_end", 32'(queue_count), 32'd0);

        // 5: reset with five entries queued
        decode_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_fetch(1'b1, 32'h500 + 32'(4 * i), 6'd9);
            tick();
        end
        drive_fetch(1'b0, 32'h0, 6'd0);
        check("t5.pre_count", 32'(queue_count), 32'd5);
        decode_stall = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5.count", 32'(queue_count), 32'd0);
        check("t5.ready", 32'(fetch_ready), 32'd1);
        expect_idle("t5.post");
        tick();
        expect_idle("t5.post2");

        // 6: steady push/pop pairs across pointer wrap
        decode_stall = 1'b1;
        drive_fetch(1'b1, 32'h600, 6'd11);
        tick();
        decode_stall = 1'b0;
        for (int k = 0; k < 20; k++) begin
            drive_fetch(1'b1, 32'h604 + 32'(4 * k), 6'd11);
            expect_issue("t6.pair", 32'h600 + 32'(4 * k), 6'd11);
            check("t6.count", 32'(queue_count), 32'd1);
            tick();
        end
        drive_fetch(1'b0, 32'h0, 6'd0);
        expect_issue("t6.last", 32'h650, 6'd11);
        tick();
        check("t6.count_end", 32'(queue_count), 32'd0);
        expect_idle("t6.end");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
